demux4_reg: RTL
===============

DEMUX4_REG -- requirements
Module: demux4_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, as the data width of the input and of each slot.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_data, input, WIDTH, the result word to route.
REQ-005 The block SHALL have port in_sel, input, 2, the destination slot: 00=a, 01=b, 10=c, 11=d.
REQ-006 The block SHALL have port in_valid, input, 1, meaning in_data/in_sel are offered.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the offer is accepted this cycle.
REQ-008 The block SHALL have ports out_a, out_b, out_c, out_d, output, WIDTH each, the per-slot held data.
REQ-009 The block SHALL have port out_valid, output, 4, the per-slot full flag; bit0=a to bit3=d.
REQ-010 The block SHALL have port consume, input, 4, the per-slot downstream take strobe; bit0=a to bit3=d.
REQ-011 The block SHALL have port overflow, output, 1, sticky overwrite flag (see Configuration).
REQ-012 The block SHALL have port accept_cnt, output, 8, the count of accepted writes.

Function
REQ-013 Each slot SHALL be a one-entry buffer; an accept occurs when in_valid and in_ready are both 1.
REQ-014 in_ready SHALL be combinational: !out_valid[in_sel] | consume[in_sel]; it SHALL not depend on in_valid.
REQ-015 On accept, the selected slot SHALL latch in_data and set its out_valid bit at the next edge (latency 1 cycle); other slots SHALL be unchanged.
REQ-016 consume[i] with out_valid[i]=1 SHALL clear out_valid[i] at the next edge, unless the same edge writes slot i, in which case out_valid[i] SHALL stay 1 with the new data.
REQ-017 consume[i] with out_valid[i]=0 SHALL be ignored.
REQ-018 Slot data SHALL hold its last value after consume; only an accept changes it.
REQ-019 Consume strobes on several slots in one cycle SHALL all take effect independently.
REQ-020 accept_cnt SHALL increment by 1 per accept and wrap from 255 to 0.

Reset
REQ-021 On rst_n low, out_a to out_d SHALL be 0, out_valid SHALL be 4'b0000, accept_cnt SHALL be 0, and overflow SHALL be 0, asynchronously.
REQ-022 A transfer in flight when reset asserts SHALL be dropped; in_ready SHALL read 1 during reset, but no accept SHALL be counted.

Configuration
REQ-023 Macro DEMUX4_REG_OVERWRITE_EN: when defined, in_ready SHALL be constant 1, a write to a full, unconsumed slot SHALL overwrite it, and overflow SHALL set and stay 1 until reset.
REQ-024 Without DEMUX4_REG_OVERWRITE_EN, REQ-014 SHALL apply and overflow SHALL be tied 0.

Structure
REQ-025 Package demux4_pkg SHALL hold the slot index enum (SLOT_A to SLOT_D), the WIDTH default and the counter width constant.
REQ-026 Sub-module demux4_slot SHALL implement one slot (data, valid, write, consume) and SHALL be instantiated four times; the top holds select decode, ready, counter and overflow.

Verification
REQ-027 The bench SHALL cover this case: after reset, in_data=16'h1234, in_sel=2, in_valid for 1 cycle -> next cycle out_c=16'h1234, out_valid=4'b0100, accept_cnt=1.
REQ-028 The bench SHALL cover this case: slot c full, no consume, offer sel=2 data=16'hBEEF -> in_ready=0, out_c remains 16'h1234, accept_cnt unchanged.
REQ-029 The bench SHALL cover this case: slot c full, consume[2]=1 and offer 16'hBEEF to sel=2 in the same cycle -> accepted, out_c=16'hBEEF, out_valid[2] stays 1.
REQ-030 The bench SHALL cover this case: all four slots full, consume=4'b1111 -> next cycle out_valid=0000 and data unchanged.
REQ-031 The bench SHALL cover this case: 256 accepts -> accept_cnt wraps to 0; assert rst_n low mid-offer -> all outputs 0 immediately.
REQ-032 The bench SHALL cover this case, with DEMUX4_REG_OVERWRITE_EN defined: full slot a overwritten with 16'h0005 -> out_a=16'h0005 and overflow=1 until reset.

Source files
------------

// File: rtl/demux4_pkg.sv
// demux4_pkg: shared slot encoding and sizing constants for the demux4_reg block.
package demux4_pkg;

    typedef enum logic [1:0] {
        SLOT_A = 2'd0,
        SLOT_B = 2'd1,
        SLOT_C = 2'd2,
        SLOT_D = 2'd3
    } slot_e;

    localparam int NUM_SLOTS = 4;
    localparam int WIDTH_DEF = 16;
    localparam int CNT_W     = 8;

endpackage

// File: rtl/demux4_slot.sv
// demux4_slot: one-entry holding buffer for a single demux destination.
// A write in the same cycle as a consume wins, so the slot stays full with new data.
module demux4_slot
    import demux4_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             consume_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (consume_i) begin
            valid_d = 1'b0;
        end
        if (wr_en_i) begin
            data_d  = wr_data_i;
            valid_d = 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments; data is reset too because the outputs must read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/demux4_reg.sv
// demux4_reg: routes one input word into one of four one-entry slots.
// Optional macro DEMUX4_REG_OVERWRITE_EN: always ready, full slots get overwritten, sticky overflow.
module demux4_reg
    import demux4_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_a,
    output logic [WIDTH-1:0]     out_b,
    output logic [WIDTH-1:0]     out_c,
    output logic [WIDTH-1:0]     out_d,
    output logic [NUM_SLOTS-1:0] out_valid,
    input  logic [NUM_SLOTS-1:0] consume,
    output logic                 overflow,
    output logic [CNT_W-1:0]     accept_cnt
);

    logic [WIDTH-1:0]     slot_data [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_valid;
    logic [NUM_SLOTS-1:0] wr_en;
    logic                 accept;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

`ifdef DEMUX4_REG_OVERWRITE_EN
    assign in_ready = 1'b1;
`else
    // A full slot can still take a word when it is being drained in the same cycle.
    assign in_ready = ~slot_valid[in_sel] | consume[in_sel];
`endif

    assign accept = in_valid & in_ready;

    always_comb begin
        wr_en         = '0;
        wr_en[in_sel] = accept;
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : gen_slot
        demux4_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en_i  (wr_en[i]),
            .wr_data_i(in_data),
            .consume_i(consume[i]),
            .data_o   (slot_data[i]),
            .valid_o  (slot_valid[i])
        );
    end

    assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, accept};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef DEMUX4_REG_OVERWRITE_EN
    logic overflow_q, overflow_d;

    assign overflow_d = overflow_q | (accept & slot_valid[in_sel] & ~consume[in_sel]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign out_a      = slot_data[SLOT_A];
    assign out_b      = slot_data[SLOT_B];
    assign out_c      = slot_data[SLOT_C];
    assign out_d      = slot_data[SLOT_D];
    assign out_valid  = slot_valid;
    assign accept_cnt = cnt_q;

endmodule
